// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI memory responder.
// Imported by the responder top level.
package spi_pkg;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam int         SPI_ADDR_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } resp_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Pad synchronizer with registered-history rise/fall pulse detect.
// All pins pass the same depth so data and clock stay aligned.
module spi_pin_sync #(
  parameter int SYNC_STG = 2,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STG{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], d_i};
      prev_q <= sync_q[SYNC_STG-1];
    end
  end

  assign q_o    = sync_q[SYNC_STG-1];
  assign rise_o = sync_q[SYNC_STG-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STG-1] & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target bridging READ/WRITE commands onto a synchronous
// memory port; sclk is oversampled in the clk domain.
module spi_mem_responder
  import spi_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic              busy
);

  logic sclk_rise, sclk_fall;
  logic cs_s, cs_fall;
  logic mosi_s;
  logic unused_sclk_q, unused_cs_rise;
  logic unused_mosi_rise, unused_mosi_fall;

  spi_pin_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk),
    .q_o    (unused_sclk_q),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // cs idles high, so its history resets high to avoid a false assert.
  spi_pin_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cs),
    .q_o    (cs_s),
    .rise_o (unused_cs_rise),
    .fall_o (cs_fall)
  );

  spi_pin_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_mosi (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mosi),
    .q_o    (mosi_s),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  resp_state_e       state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_rd_q, is_rd_d;
  logic              miso_q, miso_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rx_bits;

  assign rx_bits = {rx_q[6:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      is_rd_q    <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      is_rd_q    <= is_rd_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      rd_pend_q  <= rd_pend_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    is_rd_d    = is_rd_q;
    miso_d     = miso_q;
    busy_d     = busy_q;
    rd_en_d    = 1'b0;
    rd_pend_d  = rd_en_q;
    wr_en_d    = 1'b0;
    wdata_d    = wdata_q;

    // Memory returns data one clk after the strobe.
    if (rd_pend_q) tx_d = mem_rdata;
    if (wr_en_q) addr_d = addr_q + ADDR_W'(1);

    if (state_q != ST_IDLE && cs_s) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      miso_d    = 1'b0;
      rd_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d    = ST_CMD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            busy_d     = 1'b1;
            miso_d     = 1'b0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rx_d      = rx_bits;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              unique case (1'b1)
                (rx_bits == SPI_CMD_READ): begin
                  state_d = ST_ADDR;
                  is_rd_d = 1'b1;
                end
                (rx_bits == SPI_CMD_WRITE): begin
                  state_d = ST_ADDR;
                  is_rd_d = 1'b0;
                end
                default: state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_d    = {addr_q[ADDR_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'(SPI_ADDR_BYTES - 1)) begin
                byte_cnt_d = '0;
                if (is_rd_q) begin
                  rd_en_d = 1'b1;
                  state_d = ST_RD_DATA;
                end else begin
                  state_d = ST_WR_DATA;
                end
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d  = addr_q + ADDR_W'(1);
              rd_en_d = 1'b1;
            end
          end
        end
        ST_WR_DATA: begin
          if (sclk_rise) begin
            rx_d      = rx_bits;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_en_d = 1'b1;
              wdata_d = rx_bits;
            end
          end
        end
        ST_IGNORE: miso_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = busy_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = wdata_q;

endmodule
